codec_writer: RTL and testbench

- Output-side counterpart to the moving-average filter. The filter consumes one codec sample per `read` strobe; this block delivers processed stereo samples to the audio codec write port.
- It buffers filter results in a stereo FIFO, primes the buffer before streaming, and drives the codec `write`/`write_ready` handshake.
- It handles underrun (fill sample) and overflow (drop), and counts both.

---
 rtl/audio_pkg.sv | 10 +
 rtl/codec_writer_if.sv | 20 ++
 rtl/stereo_fifo.sv | 34 +++
 rtl/codec_writer.sv | 58 +++++
 tb/tb_codec_writer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/stereo types and writer FSM states for the codec output path
package audio_pkg;
  localparam int SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
  typedef enum logic {PRIME, STREAM} wr_state_t;
endpackage

// File: rtl/codec_writer_if.sv
// codec_writer_if: input pair handshake (sample_valid/left_in/right_in/in_ready) and codec write port (write_ready/write/writedata_*)
interface codec_writer_if;
  import audio_pkg::*;
  logic sample_valid;
  sample_t left_in;
  sample_t right_in;
  logic in_ready;
  logic write_ready;
  logic write;
  sample_t writedata_left;
  sample_t writedata_right;
  modport master (
    output sample_valid, left_in, right_in, write_ready,
    input in_ready, write, writedata_left, writedata_right
  );
  modport slave (
    input sample_valid, left_in, right_in, write_ready,
    output in_ready, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/stereo_fifo.sv
// stereo_fifo: show-ahead stereo FIFO; push/pop/din in, dout (head)/full/empty/level out, async reset of pointers
module stereo_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  stereo_t     din,
  output stereo_t     dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);
  stereo_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge CLOCK_50)
    if (push) mem[wp[AW-1:0]] <= din;
  assign level = wp - rp;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout  = mem[rp[AW-1:0]];
endmodule

// File: rtl/codec_writer.sv
// codec_writer: primes a stereo FIFO then streams pairs to the codec; bus (codec_writer_if.slave), level/streaming status, underrun/overflow saturating counters
module codec_writer
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int REPEAT_LAST = 1,
  parameter int CNT_W       = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  codec_writer_if.slave      bus,
  output logic [AW:0]        level,
  output logic               streaming,
  output logic [CNT_W-1:0]   underrun_count,
  output logic [CNT_W-1:0]   overflow_count
);
  wr_state_t state;
  stereo_t head, last_pair, held, cur;
  logic full, empty, push, pop, fill;
  assign push          = bus.sample_valid && !full;
  assign bus.in_ready  = !full;
  assign streaming     = state == STREAM;
  // write follows write_ready combinationally; async reset forces PRIME so write drops at once
  assign bus.write     = streaming && bus.write_ready;
  assign pop           = bus.write && !empty;
  assign fill          = bus.write && empty;
  assign cur           = empty ? (REPEAT_LAST != 0 ? last_pair : '0) : head;
  // held keeps the last value driven so the bus is stable while the codec stalls
  assign {bus.writedata_left, bus.writedata_right} = bus.write ? cur : held;
  stereo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      ({bus.left_in, bus.right_in}),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state          <= PRIME;
      last_pair      <= '0;
      held           <= '0;
      underrun_count <= '0;
      overflow_count <= '0;
    end else begin
      if (bus.write) held <= cur;
      if (pop) last_pair <= head;
      if (fill && !(&underrun_count)) underrun_count <= underrun_count + CNT_W'(1);
      if (bus.sample_valid && full && !(&overflow_count)) overflow_count <= overflow_count + CNT_W'(1);
      state <= streaming ? (fill ? PRIME : STREAM)
                         : (int'(level) + int'(push) >= PRIME_LEVEL ? STREAM : PRIME);
    end
endmodule

// File: tb/tb_codec_writer.sv
// tb_codec_writer: table, directed and random checks of codec_writer against a queue-based reference model
module tb_codec_writer;
  import audio_pkg::*;
  localparam int DEPTH = 16;
  localparam int PL = 8;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;
  codec_writer_if a();
  codec_writer_if b();
  assign b.sample_valid = a.sample_valid;
  assign b.left_in      = a.left_in;
  assign b.right_in     = a.right_in;
  assign b.write_ready  = a.write_ready;
  logic [4:0] level_a, level_b;
  logic streaming_a, streaming_b;
  logic [15:0] und_a, und_b, ovf_a, ovf_b;
  codec_writer #(.DEPTH(DEPTH), .PRIME_LEVEL(PL), .REPEAT_LAST(1), .CNT_W(16)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(a.slave), .level(level_a),
    .streaming(streaming_a), .underrun_count(und_a), .overflow_count(ovf_a)
  );
  codec_writer #(.DEPTH(DEPTH), .PRIME_LEVEL(PL), .REPEAT_LAST(0), .CNT_W(16)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(b.slave), .level(level_b),
    .streaming(streaming_b), .underrun_count(und_b), .overflow_count(ovf_b)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  stereo_t q[$];
  bit strm;
  stereo_t lastp, held_a, held_b;
  int und, ovf;
  task automatic model_reset;
    q.delete();
    strm = 0;
    lastp = '0;
    held_a = '0;
    held_b = '0;
    und = 0;
    ovf = 0;
  endtask
  function automatic stereo_t out_data(input bit zero_fill, input stereo_t held);
    if (!(strm && a.write_ready === 1'b1)) return held;
    if (q.size() > 0) return q[0];
    return zero_fill ? stereo_t'('0) : lastp;
  endfunction
  task automatic check_model;
    bit w;
    logic [127:0] e_a, e_b, g_a, g_b;
    w = strm && a.write_ready === 1'b1;
    e_a = {w, q.size() < DEPTH, strm, 5'(q.size()), 16'(und), 16'(ovf), out_data(0, held_a)};
    e_b = {w, q.size() < DEPTH, strm, 5'(q.size()), 16'(und), 16'(ovf), out_data(1, held_b)};
    g_a = {a.write, a.in_ready, streaming_a, level_a, und_a, ovf_a, a.writedata_left, a.writedata_right};
    g_b = {b.write, b.in_ready, streaming_b, level_b, und_b, ovf_b, b.writedata_left, b.writedata_right};
    chk("model_a", g_a, e_a);
    chk("model_b", g_b, e_b);
  endtask
  task automatic update_model;
    bit w, inr, was;
    w = strm && a.write_ready === 1'b1;
    inr = q.size() < DEPTH;
    was = strm;
    if (w) begin
      held_a = out_data(0, held_a);
      held_b = out_data(1, held_b);
      if (q.size() == 0) begin
        und = und < 65535 ? und + 1 : und;
        strm = 0;
      end else lastp = q.pop_front();
    end
    if (a.sample_valid) begin
      if (inr) q.push_back({a.left_in, a.right_in});
      else ovf = ovf < 65535 ? ovf + 1 : ovf;
    end
    if (!was && q.size() >= PL) strm = 1;
  endtask
  task automatic drive(input logic s, input int l, input int r, input logic w);
    @(negedge CLOCK_50);
    a.sample_valid = s;
    a.left_in = sample_t'(l);
    a.right_in = sample_t'(r);
    a.write_ready = w;
    #1;
  endtask
  task automatic tick;
    check_model();
    @(posedge CLOCK_50);
    update_model();
  endtask
  task automatic step(input logic s, input int l, input int r, input logic w);
    drive(s, l, r, w);
    tick();
  endtask
  typedef struct {
    logic sv;
    int   l;
    logic ew;
    int   el_a;
    int   el_b;
    int   lvl;
  } vec_t;
  vec_t tbl[17];
  initial begin
    a.sample_valid = 1'b0;
    a.left_in = '0;
    a.right_in = '0;
    a.write_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    a.write_ready = 1'b1;
    #1;
    chk("rst_write", a.write, 1'b0);
    chk("rst_in_ready", a.in_ready, 1'b1);
    chk("rst_level", level_a, 5'd0);
    chk("rst_streaming", streaming_a, 1'b0);
    chk("rst_counts", {und_a, ovf_a}, 32'd0);
    chk("rst_data", {a.writedata_left, a.writedata_right}, 48'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, i * 256, 1'b0, 0, 0, i};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b0, 0, 1'b1, i * 256, i * 256, 8 - i};
    tbl[16] = '{1'b0, 0, 1'b1, 'h700, 0, 0};
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].sv, tbl[i].l, -tbl[i].l, 1'b1);
      chk("tbl_write", a.write, tbl[i].ew);
      chk("tbl_level", level_a, 5'(tbl[i].lvl));
      if (tbl[i].ew) begin
        chk("tbl_left_a", a.writedata_left, sample_t'(tbl[i].el_a));
        chk("tbl_right_a", a.writedata_right, sample_t'(-tbl[i].el_a));
        chk("tbl_left_b", b.writedata_left, sample_t'(tbl[i].el_b));
        chk("tbl_right_b", b.writedata_right, sample_t'(-tbl[i].el_b));
      end
      tick();
    end
    drive(1'b0, 0, 0, 1'b1);
    chk("und_a_after_prime", und_a, 16'd1);
    chk("und_b_after_prime", und_b, 16'd1);
    chk("streaming_after_und", streaming_a, 1'b0);
    chk("no_second_fill", a.write, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) step(1'b1, 'h1000 + i, 'h2000 + i, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    chk("ovf_count", ovf_a, 16'd4);
    chk("ovf_level", level_a, 5'd16);
    chk("ovf_in_ready", a.in_ready, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b1);
    chk("ovf_first_out", a.writedata_left, sample_t'('h1000));
    tick();
    for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 'h10 + i, 'h20 + i, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    chk("bp_w1", {a.write, a.writedata_left}, {1'b1, sample_t'('h10)});
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("bp_w0", {a.write, a.writedata_left}, {1'b0, sample_t'('h10)});
    tick();
    drive(1'b0, 0, 0, 1'b1);
    chk("bp_w2", {a.write, a.writedata_left}, {1'b1, sample_t'('h11)});
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("bp_w3", {a.write, a.writedata_left, level_a}, {1'b0, sample_t'('h11), 5'd6});
    tick();
    for (int i = 0; i < 7; i++) step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 'h300 + i, 'h400 + i, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b1);
    chk("pre_rst_level", {a.write, level_a}, {1'b1, 5'd5});
    #1 reset = 1'b1;
    #1;
    chk("arst_write", a.write, 1'b0);
    chk("arst_level", level_a, 5'd0);
    chk("arst_counts", {und_a, ovf_a, und_b, ovf_b}, 64'd0);
    chk("arst_streaming", streaming_a, 1'b0);
    model_reset();
    #1 reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 'h500 + i, 'h600 + i, 1'b1);
      chk("post_rst_no_write", a.write, 1'b0);
      tick();
    end
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 'hFFFFFF)),
           int'($urandom_range(0, 'hFFFFFF)), $urandom_range(0, 9) < 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
